gate_unit_seq: RTL and testbench
================================

Name: gate_unit_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed two-MAC gate activation block.
- One shared MAC streams a runtime-selectable number of input products (x·w), then recurrent products (h·u), adds a latched bias, and applies a selectable activation (sigmoid, tanh, identity).
- Sits between the LSTM weight/state memories and the cell-state datapath.
- Uses valid/ready handshakes on both the input stream and the result.

Parameters:
- WIDTH, 32: data/weight/output width, signed two's complement.
- FRAC, 24: fractional bits (ONE = 1<<FRAC).
- MAX_N, 64: maximum length of either product phase.
- CNT_W, 7: length/counter width; must hold MAX_N (clog2(MAX_N+1)).
- GUARD, 8: extra accumulator integer bits; ACC_W = WIDTH+GUARD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; latches i_mode, i_nx, i_nh, i_b; accepted only in IDLE.
- i_mode  in  2  0 sigmoid, 1 tanh, 2 identity, 3 reserved (treated as identity).
- i_nx  in  CNT_W  number of x·w beats (0..MAX_N).
- i_nh  in  CNT_W  number of h·u beats (0..MAX_N).
- i_b  in  WIDTH  bias.
- i_valid  in  1  i_d/i_m beat valid.
- o_in_ready  out  1  unit accepts a beat; high only in ACC_X/ACC_H.
- i_d  in  WIDTH  x or h operand, phase-dependent.
- i_m  in  WIDTH  w or u weight.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  consumer accepts result.
- o  out  WIDTH  activated result; holds its last value between results.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, accumulator 0, counter 0; o=0, o_valid=0, o_in_ready=0, o_busy=0.
- States: IDLE -> ACC_X -> ACC_H -> BIAS -> ACT -> DONE -> IDLE.
- IDLE: on i_start, latch config, clear accumulator and counter. Next state is ACC_X if nx>0, else ACC_H if nh>0, else BIAS.
- ACC_X / ACC_H:
  - Beat fires when i_valid & o_in_ready.
  - On each beat: product = i_d*i_m (2·WIDTH), arithmetic shift right by FRAC (truncate), sign-extend to ACC_W, add to accumulator with saturation at ACC_W limits.
  - When the counter reaches nx (resp. nh), clear the counter and advance. ACC_X goes to ACC_H, or to BIAS if nh=0.
  - Cycles without a beat stall with no state change.
- BIAS: acc += sign-extended i_b (saturating); then saturate acc to WIDTH into the pre-activation register; 1 cycle.
- ACT (1 cycle; sigmf is the combinational core):
  - sigmoid: o_next = sigmf(pre).
  - tanh: o_next = 2·sigmf(sat(2·pre)) − ONE, saturated to WIDTH.
  - identity: o_next = pre.
  - The result is registered into o.
- DONE: o_valid=1. Return to IDLE on i_ready. o_valid falls on the cycle after the handshake.
- Latency from the last accepted beat to o_valid: 3 cycles (BIAS, ACT, DONE entry). With nx=nh=0: i_start to o_valid = 3 cycles.
- Boundary rules:
  - i_start outside IDLE is ignored; no effect on the running job.
  - i_nx or i_nh above MAX_N is clamped to MAX_N.
  - i_valid outside ACC states is ignored.
  - Asserting i_start in the same cycle DONE completes is ignored (state is not yet IDLE).
  - Reset mid-operation aborts the job immediately; no partial result is ever presented.
- No combinational path from i_valid to o_in_ready, or from i_ready to o_valid.

Decomposition:
- Package lstm_pkg holds:
  - mode encodings MODE_SIGM=2'd0, MODE_TANH=2'd1, MODE_ID=2'd2;
  - state enum;
  - saturate function (ACC_W→WIDTH);
  - fixed-point ONE constant.
- One sub-module, mac_sat: single-cycle multiply, shift, saturating accumulate, with clear and enable.
- The existing sigmf is instantiated as the activation core.

Test Plan:
- Identity, nx=2, nh=1, b=ONE/2:
  - x beats (ONE, 2·ONE)·(ONE, ONE/2); h beat (−ONE)·(ONE).
  - Required: o=0x01800000 (1.5), o_valid 3 cycles after the last beat.
- Sigmoid and tanh, nx=nh=0, b=0:
  - Sigmoid: o=0x00800000, o_valid 3 cycles after i_start.
  - Tanh, same config: o=0.
- Saturation, identity, nx=4:
  - Each beat 0x7FFFFFFF·0x7FFFFFFF, b=0.
  - Required: o=0x7FFFFFFF; negative operands give 0x80000000.
- Backpressure:
  - i_valid toggles every other cycle, so the accumulation stalls on idle cycles.
  - i_ready is held low for 5 cycles.
  - Required: o_valid and o stable throughout, result equals the no-stall run, and i_start during DONE is ignored.
- Reset mid-ACC_H:
  - Required: all outputs 0 within the same cycle (async).
  - A following job (identity, nx=1, beat ONE·ONE, b=0) returns o=ONE, with no residue from the aborted job.
- Clamp:
  - i_nx=MAX_N+1 (if representable): exactly MAX_N beats are accepted, then o_in_ready drops.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared configuration, encodings and saturation helpers for the LSTM gate datapath.
package lstm_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int MAX_N = 64;
  localparam int CNT_W = 7;
  localparam int GUARD = 8;
  localparam int ACC_W = WIDTH + GUARD;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  localparam logic [1:0] MODE_SIGM = 2'd0;
  localparam logic [1:0] MODE_TANH = 2'd1;
  localparam logic [1:0] MODE_ID   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC_X = 3'd1,
    S_ACC_H = 3'd2,
    S_BIAS  = 3'd3,
    S_ACT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s[ACC_W-1:0];
  endfunction

  // Value fits when every bit above the WIDTH sign bit agrees with it.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [ACC_W-1:0] v);
    if ((&v[ACC_W-1:WIDTH-1]) || (~|v[ACC_W-1:WIDTH-1]))
      sat_w = v[WIDTH-1:0];
    else
      sat_w = v[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
endpackage

// File: rtl/mac_sat.sv
// Single-cycle fixed-point multiply, truncating rescale and saturating accumulate.
module mac_sat
  import lstm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [WIDTH-1:0]        i_a,
  input  logic [WIDTH-1:0]        i_b,
  output logic signed [ACC_W-1:0] o_acc
);
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   r_acc;

  assign w_prod = $signed(i_a) * $signed(i_b);
  assign w_term = ACC_W'(w_prod >>> FRAC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= sat_add(r_acc, w_term);
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/sigmf.sv
// Piecewise-linear sigmoid (breakpoints 1, 2.375, 5; slopes 1/4, 1/8, 1/32), mirrored for x<0.
module sigmf
  import lstm_pkg::*;
(
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_y
);
  localparam logic [WIDTH:0] T_HI  = (WIDTH+1)'(5)  << FRAC;
  localparam logic [WIDTH:0] T_MID = (WIDTH+1)'(19) << (FRAC-3);
  localparam logic [WIDTH:0] T_LO  = (WIDTH+1)'(1)  << FRAC;
  localparam logic [WIDTH:0] C_HI  = (WIDTH+1)'(27) << (FRAC-5);
  localparam logic [WIDTH:0] C_MID = (WIDTH+1)'(5)  << (FRAC-3);
  localparam logic [WIDTH:0] C_LO  = (WIDTH+1)'(1)  << (FRAC-1);

  logic             w_neg;
  logic [WIDTH:0]   w_ax;
  logic [WIDTH-1:0] w_ypos;

  assign w_neg = i_x[WIDTH-1];
  assign w_ax  = w_neg ? ((WIDTH+1)'(0) - {i_x[WIDTH-1], i_x}) : {1'b0, i_x};

  always_comb begin
    w_ypos = ONE;
    if (w_ax >= T_HI)       w_ypos = ONE;
    else if (w_ax >= T_MID) w_ypos = WIDTH'((w_ax >> 5) + C_HI);
    else if (w_ax >= T_LO)  w_ypos = WIDTH'((w_ax >> 3) + C_MID);
    else                    w_ypos = WIDTH'((w_ax >> 2) + C_LO);
  end

  assign o_y = w_neg ? (ONE - w_ypos) : w_ypos;
endmodule

// File: rtl/gate_unit_seq.sv
// Time-multiplexed LSTM gate: one MAC streams x*w then h*u beats, adds bias, applies activation.
module gate_unit_seq
  import lstm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_nx,
  input  logic [CNT_W-1:0] i_nh,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_m,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_busy,
  output logic [2:0]       o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready depends only on registered state and a presented result is held until taken.
  state_t                  r_state, w_next;
  logic [1:0]              r_mode;
  logic [CNT_W-1:0]        r_nx, r_nh, r_cnt;
  logic [WIDTH-1:0]        r_b, r_pre, r_o;
  logic [CNT_W-1:0]        w_nx_cl, w_nh_cl, w_n_cur;
  logic                    w_start, w_beat, w_last;
  logic signed [ACC_W-1:0] w_acc, w_acc_b;
  logic [WIDTH-1:0]        w_pre2, w_sig_in, w_sig, w_tanh, w_act;
  logic [WIDTH:0]          w_tanh_w;

  assign w_nx_cl = (i_nx > CNT_W'(MAX_N)) ? CNT_W'(MAX_N) : i_nx;
  assign w_nh_cl = (i_nh > CNT_W'(MAX_N)) ? CNT_W'(MAX_N) : i_nh;
  assign w_start = (r_state == S_IDLE) && i_start;
  assign w_beat  = i_valid && o_in_ready;
  assign w_n_cur = (r_state == S_ACC_X) ? r_nx : r_nh;
  assign w_last  = w_beat && ((r_cnt + CNT_W'(1)) == w_n_cur);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (w_nx_cl != '0) ? S_ACC_X :
                                     (w_nh_cl != '0) ? S_ACC_H : S_BIAS;
      S_ACC_X: if (w_last) w_next = (r_nh != '0) ? S_ACC_H : S_BIAS;
      S_ACC_H: if (w_last) w_next = S_BIAS;
      S_BIAS:  w_next = S_ACT;
      S_ACT:   w_next = S_DONE;
      S_DONE:  if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == S_ACC_X) || (r_state == S_ACC_H);
    o_valid     = (r_state == S_DONE);
    o_busy      = (r_state != S_IDLE);
    o           = r_o;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= '0;
      r_nx   <= '0;
      r_nh   <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_pre  <= '0;
      r_o    <= '0;
    end else begin
      if (w_start) begin
        r_mode <= i_mode;
        r_nx   <= w_nx_cl;
        r_nh   <= w_nh_cl;
        r_b    <= i_b;
        r_cnt  <= '0;
      end else if (w_beat) begin
        r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (r_state == S_BIAS) r_pre <= sat_w(w_acc_b);
      if (r_state == S_ACT)  r_o   <= w_act;
    end
  end

  mac_sat u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_beat),
    .i_a   (i_d),
    .i_b   (i_m),
    .o_acc (w_acc)
  );

  assign w_acc_b = sat_add(w_acc, {{GUARD{r_b[WIDTH-1]}}, r_b});

  // tanh(x) = 2*sigmoid(2x) - 1, sharing the single sigmoid core.
  assign w_pre2   = sat_w({{(GUARD-1){r_pre[WIDTH-1]}}, r_pre, 1'b0});
  assign w_sig_in = (r_mode == MODE_TANH) ? w_pre2 : r_pre;
  assign w_tanh_w = {w_sig, 1'b0} - {1'b0, ONE};
  assign w_tanh   = (w_tanh_w[WIDTH] != w_tanh_w[WIDTH-1]) ?
                    (w_tanh_w[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                    w_tanh_w[WIDTH-1:0];

  sigmf u_sigmf (
    .i_x (w_sig_in),
    .o_y (w_sig)
  );

  always_comb begin
    case (r_mode)
      MODE_SIGM: w_act = w_sig;
      MODE_TANH: w_act = w_tanh;
      default:   w_act = r_pre;
    endcase
  end
endmodule

// File: tb/tb_gate_unit_seq.sv
// Bench for gate_unit_seq: directed and randomized jobs scored against an arithmetic reference.
module tb_gate_unit_seq;
  import lstm_pkg::*;

  localparam longint L_ONE = longint'(1) << FRAC;
  localparam longint A_MAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint A_MIN = -(longint'(1) << (ACC_W-1));
  localparam longint W_MAX = (longint'(1) << (WIDTH-1)) - 1;
  localparam longint W_MIN = -(longint'(1) << (WIDTH-1));

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_start = 1'b0;
  logic [1:0]       i_mode = '0;
  logic [CNT_W-1:0] i_nx = '0, i_nh = '0;
  logic [WIDTH-1:0] i_b = '0, i_d = '0, i_m = '0;
  logic             i_valid = 1'b0, i_ready = 1'b0;
  logic             o_in_ready, o_valid, o_busy;
  logic [WIDTH-1:0] o;
  logic [2:0]       o_dbg_state;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  longint      d_q[$];
  longint      m_q[$];

  gate_unit_seq dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_nx(i_nx), .i_nh(i_nh),
    .i_b(i_b), .i_valid(i_valid), .o_in_ready(o_in_ready), .i_d(i_d), .i_m(i_m),
    .o_valid(o_valid), .i_ready(i_ready), .o(o), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic longint sig_ref(input longint x);
    longint ax, y;
    ax = (x < 0) ? -x : x;
    if (ax >= 5 * L_ONE)                  y = L_ONE;
    else if (ax >= (19 * L_ONE) / 8)      y = ax / 32 + (27 * L_ONE) / 32;
    else if (ax >= L_ONE)                 y = ax / 8 + (5 * L_ONE) / 8;
    else                                  y = ax / 4 + L_ONE / 2;
    return (x < 0) ? (L_ONE - y) : y;
  endfunction

  function automatic logic [WIDTH-1:0] model(input logic [1:0] mode, input longint b);
    longint acc, pre, r;
    acc = 0;
    foreach (d_q[k]) acc = clampv(acc + ((d_q[k] * m_q[k]) >>> FRAC), A_MIN, A_MAX);
    pre = clampv(clampv(acc + b, A_MIN, A_MAX), W_MIN, W_MAX);
    case (mode)
      2'd0:    r = sig_ref(pre);
      2'd1:    r = clampv(2 * sig_ref(clampv(2 * pre, W_MIN, W_MAX)) - L_ONE, W_MIN, W_MAX);
      default: r = pre;
    endcase
    return WIDTH'(r);
  endfunction

  function automatic longint rnd_op(input longint span);
    return longint'($urandom_range(0, 32'(2 * span))) - span;
  endfunction

  // Driver: one full job. gap 0 = valid every cycle, 1 = every other cycle, 2 = random.
  task automatic run_job(input string tag, input logic [1:0] mode, input int nx, input int nh,
                         input longint b, input int gap, input int rdy_wait);
    int ncx, nch, total, idx, budget;
    int unsigned c_last;
    logic [WIDTH-1:0] exp_o, held;
    ncx   = (nx > MAX_N) ? MAX_N : nx;
    nch   = (nh > MAX_N) ? MAX_N : nh;
    total = ncx + nch;
    exp_o = model(mode, b);
    @(negedge clk);
    i_start = 1'b1; i_mode = mode; i_nx = CNT_W'(nx); i_nh = CNT_W'(nh); i_b = WIDTH'(b);
    c_last = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, " busy"}, 64'(o_busy), 64'(1));
    idx = 0; budget = 0;
    while (idx < total && budget < 4000) begin
      i_valid = (gap == 0) ? 1'b1 : (gap == 1) ? 1'(budget % 2) : 1'($urandom_range(0, 1));
      i_d = WIDTH'(d_q[idx]); i_m = WIDTH'(m_q[idx]);
      if (i_valid && o_in_ready) begin
        c_last = cyc;
        idx++;
      end
      budget++;
      @(negedge clk);
    end
    check({tag, " beats"}, 64'(idx), 64'(total));
    check({tag, " in_ready drop"}, 64'(o_in_ready), 64'(0));
    budget = 0;
    while (o_valid !== 1'b1 && budget < 20) begin
      i_valid = 1'($urandom_range(0, 1)); i_d = $urandom; i_m = $urandom;
      @(negedge clk);
      budget++;
    end
    i_valid = 1'b0;
    check({tag, " latency"}, 64'(cyc - c_last), 64'(3));
    check({tag, " result"}, 64'(o), 64'(exp_o));
    held = o;
    repeat (rdy_wait) begin
      i_start = 1'($urandom_range(0, 1)); i_nx = CNT_W'($urandom_range(0, 3));
      @(negedge clk);
      i_start = 1'b0;
      check({tag, " valid held"}, 64'(o_valid), 64'(1));
      check({tag, " o held"}, 64'(o), 64'(held));
    end
    i_ready = 1'b1; i_start = 1'b1; i_mode = MODE_ID; i_nx = '0; i_nh = '0;
    @(negedge clk);
    i_ready = 1'b0; i_start = 1'b0;
    check({tag, " valid drop"}, 64'(o_valid), 64'(0));
    check({tag, " idle after"}, 64'(o_busy), 64'(0));
    check({tag, " o keeps"}, 64'(o), 64'(held));
  endtask

  initial begin
    int nx, nh;
    logic [1:0] md;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst o", 64'(o), 64'(0));
    check("rst o_valid", 64'(o_valid), 64'(0));
    check("rst in_ready", 64'(o_in_ready), 64'(0));
    check("rst busy", 64'(o_busy), 64'(0));
    rst = 1'b1;

    // Identity 1 + 1 - 1 + 0.5
    d_q = {L_ONE, 2 * L_ONE, -L_ONE}; m_q = {L_ONE, L_ONE / 2, L_ONE};
    run_job("id_basic", MODE_ID, 2, 1, L_ONE / 2, 0, 0);
    check("id_basic value", 64'(o), 64'(32'h0180_0000));

    // Sigmoid / tanh of zero with empty phases
    d_q.delete(); m_q.delete();
    run_job("sigm0", MODE_SIGM, 0, 0, 0, 0, 1);
    check("sigm0 value", 64'(o), 64'(32'h0080_0000));
    run_job("tanh0", MODE_TANH, 0, 0, 0, 0, 0);
    check("tanh0 value", 64'(o), 64'(0));

    // Saturation both directions
    d_q = {64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'h7FFF_FFFF}; m_q = d_q;
    run_job("sat_pos", MODE_ID, 4, 0, 0, 0, 0);
    check("sat_pos value", 64'(o), 64'(32'h7FFF_FFFF));
    d_q = {-64'sh7FFF_FFFF, -64'sh7FFF_FFFF, -64'sh7FFF_FFFF, -64'sh7FFF_FFFF};
    run_job("sat_neg", MODE_ID, 4, 0, 0, 0, 0);
    check("sat_neg value", 64'(o), 64'(32'h8000_0000));

    // Backpressure replay of the basic job
    d_q = {L_ONE, 2 * L_ONE, -L_ONE}; m_q = {L_ONE, L_ONE / 2, L_ONE};
    run_job("bp", MODE_ID, 2, 1, L_ONE / 2, 1, 5);
    check("bp value", 64'(o), 64'(32'h0180_0000));

    // Reset in the middle of the h phase
    @(negedge clk);
    i_start = 1'b1; i_mode = MODE_ID; i_nx = 1; i_nh = 3; i_b = 5;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1; i_d = WIDTH'(L_ONE); i_m = WIDTH'(L_ONE);
    @(negedge clk);
    i_d = WIDTH'(3 * L_ONE);
    @(negedge clk);
    i_valid = 1'b0;
    check("mid busy", 64'(o_busy), 64'(1));
    check("mid in_ready", 64'(o_in_ready), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("abort o", 64'(o), 64'(0));
    check("abort o_valid", 64'(o_valid), 64'(0));
    check("abort in_ready", 64'(o_in_ready), 64'(0));
    check("abort busy", 64'(o_busy), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    d_q = {L_ONE}; m_q = {L_ONE};
    run_job("post_rst", MODE_ID, 1, 0, 0, 0, 0);
    check("post_rst value", 64'(o), 64'(L_ONE));

    // Length clamp: 65 requested, 64 accepted
    d_q.delete(); m_q.delete();
    for (int k = 0; k < MAX_N; k++) begin
      d_q.push_back(rnd_op(L_ONE)); m_q.push_back(rnd_op(L_ONE));
    end
    run_job("clamp", MODE_ID, MAX_N + 1, 0, 0, 0, 0);

    // Randomized jobs over all modes
    for (int j = 0; j < 12; j++) begin
      md = 2'($urandom_range(0, 3));
      nx = $urandom_range(0, 8);
      nh = $urandom_range(0, 8);
      d_q.delete(); m_q.delete();
      for (int k = 0; k < nx + nh; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          d_q.push_back(longint'($signed($urandom))); m_q.push_back(longint'($signed($urandom)));
        end else begin
          d_q.push_back(rnd_op(4 * L_ONE)); m_q.push_back(rnd_op(2 * L_ONE));
        end
      end
      run_job($sformatf("rand%0d", j), md, nx, nh, rnd_op(2 * L_ONE), 2, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
